// File: rtl/write_back.sv
// Y86-64 write-back stage: architectural register file, status register and
// retired-instruction counter. Two combinational read ports serve decode.
module write_back (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [3:0]  icode_i,
  input  logic        instr_valid_i,
  input  logic        imem_error_i,
  input  logic        dmem_error_i,
  input  logic        cnd_i,
  input  logic [3:0]  dstE_i,
  input  logic [3:0]  dstM_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valM_i,
  input  logic [3:0]  srcA_i,
  input  logic [3:0]  srcB_i,
  output logic [63:0] valA_o,
  output logic [63:0] valB_o,
  output logic [3:0]  stat_o,
  output logic        halted_o,
  output logic [63:0] instret_o
);

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [3:0] {
    S_AOK = 4'd1,
    S_HLT = 4'd2,
    S_ADR = 4'd3,
    S_INS = 4'd4
  } stat_t;

  stat_t       stat_q;
  stat_t       instr_stat;
  logic [63:0] rf [15];
  logic [63:0] instret_q;
  logic        commit;
  logic        retire;
  logic        we_e;
  logic        we_m;

  always_comb begin
    instr_stat = S_AOK;
    if (imem_error_i || dmem_error_i) instr_stat = S_ADR;
    else if (!instr_valid_i)          instr_stat = S_INS;
    else if (icode_i == IHALT)        instr_stat = S_HLT;
  end

  assign halted_o = (stat_q != S_AOK);
  assign commit   = valid_i && !halted_o;
  assign retire   = commit && ((instr_stat == S_AOK) || (instr_stat == S_HLT));
  // cmovXX is encoded as rrmovq; a false condition drops the E-port write
  assign we_e     = retire && (dstE_i != RNONE) && !((icode_i == IRRMOVQ) && !cnd_i);
  assign we_m     = retire && (dstM_i != RNONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q    <= S_AOK;
      instret_q <= '0;
      for (int unsigned i = 0; i < 15; i++) rf[i] <= '0;
    end else begin
      if (commit) stat_q <= instr_stat;
      if (retire) instret_q <= instret_q + 64'd1;
      // M port has priority on a shared destination (popq %rsp)
      for (int unsigned i = 0; i < 15; i++) begin
        if (we_m && (dstM_i == 4'(i)))      rf[i] <= valM_i;
        else if (we_e && (dstE_i == 4'(i))) rf[i] <= valE_i;
      end
    end
  end

  always_comb begin
    valA_o = '0;
    valB_o = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      if (srcA_i == 4'(i)) valA_o = rf[i];
      if (srcB_i == 4'(i)) valB_o = rf[i];
    end
  end

  assign stat_o    = stat_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: behavioural model compared every cycle,
// plus directed literal expectations along the test plan.
module tb_write_back;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [3:0]  icode_i = 4'h1;
  logic        instr_valid_i = 1'b1;
  logic        imem_error_i = 1'b0;
  logic        dmem_error_i = 1'b0;
  logic        cnd_i = 1'b0;
  logic [3:0]  dstE_i = 4'hF;
  logic [3:0]  dstM_i = 4'hF;
  logic [63:0] valE_i = '0;
  logic [63:0] valM_i = '0;
  logic [3:0]  srcA_i = 4'hF;
  logic [3:0]  srcB_i = 4'hF;
  logic [63:0] valA_o;
  logic [63:0] valB_o;
  logic [3:0]  stat_o;
  logic        halted_o;
  logic [63:0] instret_o;

  int n_cmp = 0;
  int n_err = 0;

  write_back dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .icode_i(icode_i),
    .instr_valid_i(instr_valid_i), .imem_error_i(imem_error_i),
    .dmem_error_i(dmem_error_i), .cnd_i(cnd_i), .dstE_i(dstE_i),
    .dstM_i(dstM_i), .valE_i(valE_i), .valM_i(valM_i), .srcA_i(srcA_i),
    .srcB_i(srcB_i), .valA_o(valA_o), .valB_o(valB_o), .stat_o(stat_o),
    .halted_o(halted_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  // Model: architectural state updated from the instruction-level rules
  logic [63:0] m_r [15];
  logic [3:0]  m_stat;
  logic [63:0] m_instret;

  function automatic logic [3:0] instr_status(input logic ie, de, iv, input logic [3:0] ic);
    if (ie || de) return 4'd3;
    if (!iv)      return 4'd4;
    if (ic == 4'h0) return 4'd2;
    return 4'd1;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] r);
    if (r == 4'hF) return 64'd0;
    return m_r[r];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stat    <= 4'd1;
      m_instret <= 64'd0;
      for (int k = 0; k < 15; k++) m_r[k] <= 64'd0;
    end else if (valid_i && m_stat == 4'd1) begin
      logic [3:0] s;
      s = instr_status(imem_error_i, dmem_error_i, instr_valid_i, icode_i);
      m_stat <= s;
      if (s == 4'd1 || s == 4'd2) begin
        m_instret <= m_instret + 64'd1;
        if (dstE_i != 4'hF && !(icode_i == 4'h2 && !cnd_i)) m_r[dstE_i] <= valE_i;
        if (dstM_i != 4'hF) m_r[dstM_i] <= valM_i;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_valA", valA_o, m_read(srcA_i));
    chk("cyc_valB", valB_o, m_read(srcB_i));
    chk("cyc_stat", {60'd0, stat_o}, {60'd0, m_stat});
    chk("cyc_halted", {63'd0, halted_o}, {63'd0, m_stat != 4'd1});
    chk("cyc_instret", instret_o, m_instret);
  end

  task automatic commit(input logic [3:0] ic, input logic iv, ie, de, cn,
                        input logic [3:0] de_r, dm_r, input logic [63:0] ve, vm);
    @(negedge clk); #1;
    valid_i = 1'b1; icode_i = ic; instr_valid_i = iv; imem_error_i = ie;
    dmem_error_i = de; cnd_i = cn; dstE_i = de_r; dstM_i = dm_r;
    valE_i = ve; valM_i = vm;
    @(posedge clk); #1;
    valid_i = 1'b0; imem_error_i = 1'b0; dmem_error_i = 1'b0; instr_valid_i = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, b);
    @(negedge clk); #1;
    srcA_i = a; srcB_i = b;
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk); #1;
    valid_i = 1'b1; icode_i = 4'h3; dstE_i = 4'h8; valE_i = 64'hBAD;
    #2 rst = 1'b1;
    #1;
    chk("ar_stat", {60'd0, stat_o}, 64'd1);
    chk("ar_halted", {63'd0, halted_o}, 64'd0);
    chk("ar_instret", instret_o, 64'd0);
    chk("ar_valA", valA_o, 64'd0);
    @(negedge clk); #1 valid_i = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_stat", {60'd0, stat_o}, 64'd1);
    chk("rst_instret", instret_o, 64'd0);
    #1 rst = 1'b0;

    // irmovq then read back
    commit(4'h3, 1, 0, 0, 0, 4'h0, 4'hF, 64'h1234, 64'h0);
    rd(4'h0, 4'hF);
    chk("irmovq_valA", valA_o, 64'h1234);
    chk("irmovq_valB_rnone", valB_o, 64'd0);
    chk("irmovq_instret", instret_o, 64'd1);

    // popq %rsp: M wins; then split destinations
    commit(4'hB, 1, 0, 0, 0, 4'h4, 4'h4, 64'h100, 64'hDEAD);
    rd(4'h4, 4'h0);
    chk("pop_same_dst", valA_o, 64'hDEAD);
    commit(4'hB, 1, 0, 0, 0, 4'h4, 4'h3, 64'h200, 64'h300);
    rd(4'h4, 4'h3);
    chk("pop_split_E", valA_o, 64'h200);
    chk("pop_split_M", valB_o, 64'h300);

    // cmov false then true, with same-cycle read of the target
    rd(4'h2, 4'h2);
    commit(4'h2, 1, 0, 0, 0, 4'h2, 4'hF, 64'h7, 64'h0);
    rd(4'h2, 4'hF);
    chk("cmov_false", valA_o, 64'd0);
    commit(4'h2, 1, 0, 0, 1, 4'h2, 4'hF, 64'h7, 64'h0);
    rd(4'h2, 4'hF);
    chk("cmov_true", valA_o, 64'h7);
    chk("cmov_instret", instret_o, 64'd5);

    // idle cycles with junk on the inputs change nothing
    @(negedge clk); #1 dstE_i = 4'h9; valE_i = 64'hFFFF; icode_i = 4'h0;
    repeat (2) @(negedge clk);

    // data fault
    commit(4'h5, 1, 0, 1, 0, 4'hF, 4'h5, 64'h0, 64'h55);
    rd(4'h5, 4'h6);
    chk("dfault_R5", valA_o, 64'd0);
    chk("dfault_stat", {60'd0, stat_o}, 64'd3);
    chk("dfault_halted", {63'd0, halted_o}, 64'd1);
    chk("dfault_instret", instret_o, 64'd5);
    commit(4'h3, 1, 0, 0, 0, 4'h6, 4'hF, 64'h9, 64'h0);
    rd(4'h6, 4'h4);
    chk("after_fault_R6", valA_o, 64'd0);
    chk("after_fault_R4", valB_o, 64'h200);

    rd(4'h4, 4'h3);
    async_reset();

    // halt: counts, then freezes
    commit(4'h3, 1, 0, 0, 0, 4'h1, 4'hF, 64'h11, 64'h0);
    commit(4'h0, 1, 0, 0, 0, 4'hF, 4'hF, 64'h0, 64'h0);
    rd(4'h1, 4'hF);
    chk("halt_stat", {60'd0, stat_o}, 64'd2);
    chk("halt_instret", instret_o, 64'd2);
    commit(4'h3, 1, 0, 0, 0, 4'h1, 4'hF, 64'h22, 64'h0);
    rd(4'h1, 4'hF);
    chk("halt_frozen_R1", valA_o, 64'h11);
    chk("halt_frozen_instret", instret_o, 64'd2);
    async_reset();

    // invalid instruction and imem fault each halt without writing
    commit(4'h3, 0, 0, 0, 0, 4'h7, 4'hF, 64'h77, 64'h0);
    rd(4'h7, 4'hF);
    chk("ins_stat", {60'd0, stat_o}, 64'd4);
    chk("ins_R7", valA_o, 64'd0);
    async_reset();
    commit(4'h3, 1, 1, 0, 0, 4'h7, 4'hF, 64'h77, 64'h0);
    rd(4'h7, 4'hF);
    chk("imem_stat", {60'd0, stat_o}, 64'd3);
    chk("imem_instret", instret_o, 64'd0);

    repeat (2) @(negedge clk);
    #2 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/write_back.md
# write_back

Write-back stage and architectural register file for the Y86-64 core. It sits directly downstream of the memory-access stage. It commits valE (ALU/address result) and valM (data-memory read) into the fifteen 64-bit program registers and serves the decode stage's two combinational read ports. It also owns the processor status register: the first exception or halt freezes all further architectural writes, and a retired-instruction counter is provided for test/debug.

## Interface
Parameters:
- none (the register count of 15, data width of 64 and status encodings are fixed by `define.v`)

Ports:
- clk_i  in  1  core clock; all state updates on its rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  an instruction is present for commit this cycle
- icode_i  in  4  instruction code (`IHALT`..`IPOPQ` from `define.v`)
- instr_valid_i  in  1  the decode stage recognised icode/ifun
- imem_error_i  in  1  the instruction fetch faulted
- dmem_error_i  in  1  the data access faulted (from memory_access)
- cnd_i  in  1  condition outcome from execute; used only for cmovXX
- dstE_i  in  4  register ID to receive valE; 4'hF (RNONE) means no write
- dstM_i  in  4  register ID to receive valM; 4'hF means no write
- valE_i  in  64  execute result
- valM_i  in  64  memory read data
- srcA_i  in  4  decode read-port A register ID
- srcB_i  in  4  decode read-port B register ID
- valA_o  out  64  contents of register srcA_i; 0 when srcA_i is 4'hF
- valB_o  out  64  contents of register srcB_i; 0 when srcB_i is 4'hF
- stat_o  out  4  status: AOK=1, HLT=2, ADR=3, INS=4
- halted_o  out  1  high when stat_o is not AOK
- instret_o  out  64  count of committed instructions

## Operation
- **Commit condition:** commit = valid_i && !halted_o.
- **Per-instruction status** (priority order):
  - ADR if imem_error_i or dmem_error_i
  - else INS if !instr_valid_i
  - else HLT if icode_i == `IHALT`
  - else AOK
- **Register writes** happen on commit only when the per-instruction status is AOK or HLT. ADR and INS instructions write nothing.
  - E port: writes valE_i to R[dstE_i] when dstE_i != 4'hF. It is suppressed when icode_i == `IRRMOVQ` (cmovXX) and cnd_i == 0.
  - M port: writes valM_i to R[dstM_i] when dstM_i != 4'hF.
  - When dstE_i == dstM_i and both ports are enabled, the M port wins. This is the popq %rsp rule: the final value is valM_i.
- **Status register:** on commit, stat_o takes the per-instruction status. Once stat_o is not AOK it holds until reset, and every later input is ignored.
- **instret_o:** increments by 1 (wrapping modulo 2^64) on each commit whose status is AOK or HLT. A faulting instruction does not count.
- **Read ports:** purely combinational from the array. There is no write-through bypass, so a same-cycle read returns the pre-edge value.

## Timing
- **Reset:** while rst_i is high, all 15 registers are 0, stat_o is AOK (1), halted_o is 0 and instret_o is 0. Reset takes effect immediately, without waiting for a clock edge. Assertion mid-commit discards that commit.
- **Write latency:** one edge. Data presented in cycle N is visible on valA_o/valB_o from cycle N+1.
- **halted_o** is registered: it rises in the cycle after the halting or faulting instruction commits. That instruction's own permitted writes still happen.
- **valid_i low:** no state changes at all.
- **Stall-free:** the block has no handshake back to upstream and never back-pressures it.

## Test plan
- **Reset and writes:** reset, then commit irmovq with dstE=0, valE=0x1234. Next cycle srcA=0 gives valA_o=0x1234, stat_o=1 and instret_o=1.
- **Port conflict:** popq with dstE=4, dstM=4, valE=0x100, valM=0xDEAD. Then R4=0xDEAD. Separately, dstE=4, dstM=3 writes both registers.
- **cmov:** icode=2, cnd_i=0, dstE=2, valE=7 leaves R2 unchanged. The same with cnd_i=1 gives R2=7.
- **Data fault:** mrmovq with dmem_error_i=1 and dstM=5 leaves R5 unchanged, sets stat_o=3, raises halted_o the next cycle and leaves instret_o unchanged. A following irmovq writes nothing.
- **Halt:** icode=0 sets stat_o=2 and increments instret_o. Any later commit has no effect.
- **Async reset after halt:** asserting rst_i between clock edges after a halt clears stat_o to 1, halted_o to 0, instret_o to 0 and all registers to 0 immediately. Register 0xF reads return 0 at all times.
